pipe_core_p: RTL

Parametrised 3-register in-order pipeline core (ID → EX → WB) that generalises the fixed IF/ID/EX demonstrator. It adds:
- configurable data and register-address widths;
- an internal register file with writeback and full operand forwarding;
- valid/ready backpressure on both instruction input and result output;
- synchronous flush and a retire counter.

It sits between an external fetch source (e.g. the instruction ROM stage) and any result sink.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/alu_p.sv | 28 ++
 rtl/pipe_core_p.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_core_p pipeline: ALU opcodes, the immediate-select
// bit and instruction field offsets for the {op, rd, rs1, imm} word.
package pipe_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM_BIT = 3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Field LSB positions; imm always starts at bit 0
  function automatic int unsigned rs1_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned data_w, input int unsigned ra_w);
    return data_w + ra_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned data_w, input int unsigned ra_w);
    return data_w + 2 * ra_w;
  endfunction

  function automatic int unsigned instr_w(input int unsigned data_w, input int unsigned ra_w);
    return OP_W + 2 * ra_w + data_w;
  endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU: add/sub/logic/single-bit shifts/pass-B, all modulo 2^DATA_W.
module alu_p
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y_c
);

  always_comb begin
    y_c = '0;
    case (op)
      OP_ADD:  y_c = a + b;
      OP_SUB:  y_c = a - b;
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_SHL:  y_c = a << 1;
      OP_SHR:  y_c = a >> 1;
      OP_PASS: y_c = b;
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/pipe_core_p.sv
// Three-register in-order pipeline (ID -> EX -> WB) with register file, full operand
// forwarding, valid/ready backpressure on both ends, synchronous flush and retire counter.
module pipe_core_p
  import pipe_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned RA_W    = 3,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned INSTR_W = instr_w(DATA_W, RA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RA_W-1:0]    out_rd,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int unsigned REG_N   = 1 << RA_W;
  localparam int unsigned RS1_LSB = rs1_lsb(DATA_W);
  localparam int unsigned RD_LSB  = rd_lsb(DATA_W, RA_W);
  localparam int unsigned OP_LSB  = op_lsb(DATA_W, RA_W);

  logic               v1, v2, v3;
  logic [INSTR_W-1:0] instr1;
  logic [2:0]         op2;
  logic [RA_W-1:0]    rd2, rd3;
  logic [DATA_W-1:0]  a2, b2, data3;
  logic [DATA_W-1:0]  regs [REG_N];
  logic [CNT_W-1:0]   cnt;

  logic               en1_c, en2_c, en3_c, accept_c, retire_c;
  logic [OP_W-1:0]    op1_c;
  logic [RA_W-1:0]    rd1_c, rs1_c, rs2_c;
  logic [DATA_W-1:0]  imm1_c, a1_c, rb1_c, b1_c, alu_y_c;

  // Handshake: a stage advances when it is empty or its successor advances
  always_comb begin
    en3_c    = !v3 || out_ready;
    en2_c    = !v2 || en3_c;
    en1_c    = !v1 || en2_c;
    in_ready = en1_c && !flush;
    accept_c = in_valid && in_ready;
    retire_c = v3 && out_ready && !flush;
  end

  // S1 field decode
  always_comb begin
    op1_c  = instr1[OP_LSB +: OP_W];
    rd1_c  = instr1[RD_LSB +: RA_W];
    rs1_c  = instr1[RS1_LSB +: RA_W];
    imm1_c = instr1[DATA_W-1:0];
    rs2_c  = imm1_c[RA_W-1:0];
  end

  // Operand read with forwarding: EX result beats WB data beats register file
  always_comb begin
    a1_c  = regs[rs1_c];
    rb1_c = regs[rs2_c];
    if (v2 && rd2 == rs1_c)      a1_c = alu_y_c;
    else if (v3 && rd3 == rs1_c) a1_c = data3;
    if (v2 && rd2 == rs2_c)      rb1_c = alu_y_c;
    else if (v3 && rd3 == rs2_c) rb1_c = data3;
    b1_c = op1_c[IMM_BIT] ? imm1_c : rb1_c;
  end

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .op  (op2),
    .a   (a2),
    .b   (b2),
    .y_c (alu_y_c)
  );

  // Pipeline registers; payloads load only with a valid instruction so WB holds under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      instr1 <= '0;
      op2    <= '0;
      rd2    <= '0;
      a2     <= '0;
      b2     <= '0;
      rd3    <= '0;
      data3  <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en3_c) begin
        v3 <= v2;
        if (v2) begin
          rd3   <= rd2;
          data3 <= alu_y_c;
        end
      end
      if (en2_c) begin
        v2 <= v1;
        if (v1) begin
          op2 <= op1_c[2:0];
          rd2 <= rd1_c;
          a2  <= a1_c;
          b2  <= b1_c;
        end
      end
      if (en1_c) begin
        v1 <= accept_c;
        if (accept_c) instr1 <= in_instr;
      end
    end
  end

  // Writeback and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (retire_c) begin
      regs[rd3] <= data3;
      cnt       <= cnt + CNT_W'(1);
    end
  end

  assign out_valid  = v3;
  assign out_rd     = rd3;
  assign out_data   = data3;
  assign retire_cnt = cnt;

endmodule
